// File: rtl/seq_unit.sv
// Program sequencer: PC, LIFO return stack, branch resolution, halt/stall.
// Optional interrupt entry/RETI enabled by defining SEQ_IRQ_EN.
module seq_unit #(
  parameter int                WIDTH       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter int                SP_W        = 3,
  parameter logic [WIDTH-1:0]  RESET_ADDR  = '0,
  parameter logic [WIDTH-1:0]  IRQ_VECTOR  = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [1:0]       cond_sel,
  input  logic             cond_inv,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_b,
  input  logic [WIDTH-1:0] target,
  input  logic             irq,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic [SP_W-1:0]  depth,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_JREL  = 3'd2;
  localparam logic [2:0] OP_JCOND = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_HALT  = 3'd6;
  localparam logic [2:0] OP_RETI  = 3'd7;

  localparam int              IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL  = SP_W'(STACK_DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [SP_W-1:0]   depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WIDTH-1:0]  stack_q [STACK_DEPTH];

  logic              full, empty, cond_true, sel_flag, is_ret, push_en;
  logic [WIDTH-1:0]  pc_inc, push_data, stack_top;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign full      = (depth_q == FULL);
  assign empty     = (depth_q == '0);
  assign pc_inc    = pc_q + WIDTH'(1);
  assign push_idx  = depth_q[IDX_W-1:0];
  assign pop_idx   = push_idx - IDX_W'(1);
  assign stack_top = stack_q[pop_idx];

  always_comb begin
    sel_flag = 1'b1;
    case (cond_sel)
      2'd0:    sel_flag = flag_z;
      2'd1:    sel_flag = flag_c;
      2'd2:    sel_flag = flag_b;
      default: sel_flag = 1'b1;
    endcase
  end
  assign cond_true = cond_inv ^ sel_flag;

`ifdef SEQ_IRQ_EN
  logic in_isr_q, in_isr_d;
  assign is_ret = (op == OP_RET) || (op == OP_RETI);
`else
  // Without interrupts op 7 falls through to the NEXT default below.
  assign is_ret = (op == OP_RET);
  logic unused_irq;
  assign unused_irq = ^{irq, IRQ_VECTOR};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    push_data = pc_inc;
`ifdef SEQ_IRQ_EN
    in_isr_d  = in_isr_q;
`endif
    if (state_q == S_RUN && !stall) begin
`ifdef SEQ_IRQ_EN
      // Interrupt pre-empts the current op; its own pc is the return address.
      if (irq && !in_isr_q && !full) begin
        push_en   = 1'b1;
        push_data = pc_q;
        pc_d      = IRQ_VECTOR;
        depth_d   = depth_q + SP_W'(1);
        in_isr_d  = 1'b1;
      end else
`endif
      if (is_ret) begin
        if (empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d    = stack_top;
          depth_d = depth_q - SP_W'(1);
        end
`ifdef SEQ_IRQ_EN
        if (op == OP_RETI) in_isr_d = 1'b0;
`endif
      end else begin
        case (op)
          OP_JMP:   pc_d = target;
          OP_JREL:  pc_d = pc_q + target;
          OP_JCOND: pc_d = cond_true ? target : pc_inc;
          OP_CALL: begin
            if (full) begin
              pc_d  = pc_inc;
              ovf_d = 1'b1;
            end else begin
              push_en = 1'b1;
              pc_d    = target;
              depth_d = depth_q + SP_W'(1);
            end
          end
          OP_HALT:  state_d = S_HALT;
          default:  pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) in_isr_q <= 1'b0;
    else     in_isr_q <= in_isr_d;
  end
`endif

  // Stack storage is deliberately not reset; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en && !rst) stack_q[push_idx] <= push_data;
  end

  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign depth   = depth_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule
